// File: rtl/scr1_tcm_ctrl.sv
// TCM request/response controller: IMEM/DMEM to dual-port memory strobes.
// Optional output register stage enabled by SCR1_TCM_RDATA_REG_EN.
module scr1_tcm_ctrl #(
  parameter int SCR1_TCM_SIZE = 'h00010000,
  parameter int SCR1_AWIDTH   = 32,
  parameter int MA            = $clog2(SCR1_TCM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_req,
  output logic                   imem_req_ack,
  input  logic [SCR1_AWIDTH-1:0] imem_addr,
  output logic [31:0]            imem_rdata,
  output logic [1:0]             imem_resp,
  input  logic                   dmem_req,
  input  logic                   dmem_cmd,
  input  logic [1:0]             dmem_width,
  input  logic [SCR1_AWIDTH-1:0] dmem_addr,
  input  logic [31:0]            dmem_wdata,
  output logic                   dmem_req_ack,
  output logic [31:0]            dmem_rdata,
  output logic [1:0]             dmem_resp,
  output logic                   mem_rena,
  output logic [MA-3:0]          mem_addra,
  input  logic [31:0]            mem_qa,
  output logic                   mem_renb,
  output logic                   mem_wenb,
  output logic [3:0]             mem_webb,
  output logic [MA-3:0]          mem_addrb,
  output logic [31:0]            mem_datab,
  input  logic [31:0]            mem_qb
);

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ER   = 2'b10;

  logic        d_ill;
  logic        d_rd;
  logic        d_wr;
  logic        i_mis;
  logic        hazard;
  logic [1:0]  i_st;
  logic [1:0]  d_st;
  logic        d_rdq;
  logic [1:0]  d_off;
  logic [1:0]  d_wid;
  logic [31:0] d_sh;
  logic [31:0] d_al;
  logic [31:0] i_data;
  logic [31:0] d_data;
  logic        unused_hi;

  assign unused_hi = ^{imem_addr[SCR1_AWIDTH-1:MA],
                       dmem_addr[SCR1_AWIDTH-1:MA]};

  // Request decode, hazard detection and memory strobes
  always_comb begin
    d_ill = 1'b0;
    unique case (dmem_width)
      2'b00:   d_ill = 1'b0;
      2'b01:   d_ill = dmem_addr[0];
      2'b10:   d_ill = |dmem_addr[1:0];
      default: d_ill = 1'b1;
    endcase
    d_rd   = dmem_req & ~d_ill & ~dmem_cmd;
    d_wr   = dmem_req & ~d_ill & dmem_cmd;
    i_mis  = |imem_addr[1:0];
    hazard = d_wr & imem_req
           & (imem_addr[MA-1:2] == dmem_addr[MA-1:2]);
    imem_req_ack = imem_req & ~hazard;
    dmem_req_ack = 1'b1;
    mem_rena  = imem_req & ~hazard & ~i_mis;
    mem_addra = imem_addr[MA-1:2];
    mem_renb  = d_rd;
    mem_wenb  = d_wr;
    mem_addrb = dmem_addr[MA-1:2];
    mem_webb  = 4'b0000;
    mem_datab = dmem_wdata;
    unique case (dmem_width)
      2'b00: begin
        mem_webb  = 4'b0001 << dmem_addr[1:0];
        mem_datab = {4{dmem_wdata[7:0]}};
      end
      2'b01: begin
        mem_webb  = 4'b0011 << dmem_addr[1:0];
        mem_datab = {2{dmem_wdata[15:0]}};
      end
      default: mem_webb = 4'b1111;
    endcase
    if (!d_wr) mem_webb = 4'b0000;
  end

  // Response stage: status plus load offset/width for alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_st  <= RESP_IDLE;
      d_st  <= RESP_IDLE;
      d_rdq <= 1'b0;
      d_off <= 2'b00;
      d_wid <= 2'b00;
    end else begin
      i_st  <= imem_req_ack ? (i_mis ? RESP_ER : RESP_OK) : RESP_IDLE;
      d_st  <= dmem_req ? (d_ill ? RESP_ER : RESP_OK) : RESP_IDLE;
      d_rdq <= d_rd;
      d_off <= dmem_addr[1:0];
      d_wid <= dmem_width;
    end
  end

  // Load data alignment with zero fill above the access width
  always_comb begin
    d_sh = mem_qb >> {d_off, 3'b000};
    d_al = d_sh;
    unique case (d_wid)
      2'b00:   d_al = {24'h0, d_sh[7:0]};
      2'b01:   d_al = {16'h0, d_sh[15:0]};
      default: d_al = d_sh;
    endcase
    i_data = (i_st == RESP_OK) ? mem_qa : 32'h0;
    d_data = d_rdq ? d_al : 32'h0;
  end

`ifdef SCR1_TCM_RDATA_REG_EN
  // Extra output stage: two-cycle latency, full throughput
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_resp  <= RESP_IDLE;
      imem_rdata <= 32'h0;
      dmem_resp  <= RESP_IDLE;
      dmem_rdata <= 32'h0;
    end else begin
      imem_resp  <= i_st;
      imem_rdata <= i_data;
      dmem_resp  <= d_st;
      dmem_rdata <= d_data;
    end
  end
`else
  assign imem_resp  = i_st;
  assign imem_rdata = i_data;
  assign dmem_resp  = d_st;
  assign dmem_rdata = d_data;
`endif

endmodule
